tree_msg_encoder: RTL and testbench

TREE_MSG_ENCODER -- requirements
Module: tree_msg_encoder

---
 rtl/tree_enc_pkg.sv | 37 +++
 rtl/varint_serializer.sv | 19 +
 rtl/tree_msg_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_tree_msg_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_enc_pkg.sv
`default_nettype none
// ============================================================================
// Package : tree_enc_pkg
// Shared types for the protobuf tree message encoder.
// Revision: 1.0
// ============================================================================
package tree_enc_pkg;

  typedef enum logic [2:0] {
    WT_VARINT  = 3'd0,
    WT_LEN     = 3'd2,
    WT_FIXED32 = 3'd5
  } wire_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TAG    = 2'd1,
    ST_VARINT = 2'd2,
    ST_FIXED  = 2'd3
  } state_e;

  // The field id is folded into the tag shift register at accept time,
  // so the latched record only needs what the later states consume.
  typedef struct packed {
    logic [31:0] value;
    logic [2:0]  wire_type;
    logic        last;
  } field_rec_t;

  localparam int VARINT_MAX_BYTES = 5;

  function automatic logic wt_supported(input logic [2:0] wt);
    return (wt == WT_VARINT) || (wt == WT_LEN) || (wt == WT_FIXED32);
  endfunction

endpackage
`default_nettype wire

// File: rtl/varint_serializer.sv
`default_nettype none
// ============================================================================
// Module  : varint_serializer
// Produces one varint byte (7 data bits + continuation) and the residual.
// Revision: 1.0
// ============================================================================
module varint_serializer (
  input  logic [31:0] in_value,
  output logic [7:0]  out_byte,
  output logic        out_more,
  output logic [31:0] out_rest
);

  assign out_rest = in_value >> 7;
  assign out_more = |out_rest;
  assign out_byte = {out_more, in_value[6:0]};

endmodule
`default_nettype wire

// File: rtl/tree_msg_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tree_msg_encoder
// Serializes field records into protobuf bytes; optional nesting-length
// checking is enabled with TREE_ENC_LEN_CHECK_EN.
// Revision: 1.0
// ============================================================================
module tree_msg_encoder
  import tree_enc_pkg::*;
#(
  parameter int IDENTIFIER_SIZE   = 5,
  parameter int NUM_MSG_HIERARCHY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IDENTIFIER_SIZE-1:0] in_field_id,
  input  logic [2:0]                 in_wire_type,
  input  logic [31:0]                in_value,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  output logic                       wt_err,
  output logic                       len_err
);

  localparam int TAG_W = IDENTIFIER_SIZE + 3;

  state_e      state_q, state_d;
  field_rec_t  rec_q, rec_d;
  logic [31:0] work_q, work_d;
  logic [2:0]  idx_q, idx_d;
  logic        in_ready_q, in_ready_d;
  logic        wt_err_q, wt_err_d;

  logic [TAG_W-1:0] tag;
  logic [7:0]       ser_byte;
  logic             ser_more;
  logic [31:0]      ser_rest;
  logic             accept;
  logic             byte_done;
  logic             rec_final;

  varint_serializer u_ser (
    .in_value (work_q),
    .out_byte (ser_byte),
    .out_more (ser_more),
    .out_rest (ser_rest)
  );

  assign tag       = {in_field_id, in_wire_type};
  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q != ST_IDLE);
  assign byte_done = out_valid && out_ready;
  assign rec_final = ((state_q == ST_VARINT) &&
                      (!ser_more || idx_q == 3'(VARINT_MAX_BYTES - 1))) ||
                     ((state_q == ST_FIXED) && (idx_q == 3'd3));

  assign in_ready = in_ready_q;
  assign wt_err   = wt_err_q;
  assign out_last = rec_final && rec_q.last;

  always_comb begin
    out_data = 8'h00;
    case (state_q)
      ST_TAG, ST_VARINT: out_data = ser_byte;
      ST_FIXED:          out_data = work_q[7:0];
      default:           out_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rec_d    = rec_q;
    work_d   = work_q;
    idx_d    = idx_q;
    wt_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rec_d = '{value: in_value, wire_type: in_wire_type, last: in_last};
          if (wt_supported(in_wire_type)) begin
            state_d = ST_TAG;
            work_d  = 32'(tag);
            idx_d   = 3'd0;
          end else begin
            wt_err_d = 1'b1;
          end
        end
      end
      ST_TAG: begin
        if (byte_done) begin
          if (ser_more) begin
            work_d = ser_rest;
          end else begin
            work_d  = rec_q.value;
            idx_d   = 3'd0;
            state_d = (rec_q.wire_type == WT_FIXED32) ? ST_FIXED : ST_VARINT;
          end
        end
      end
      ST_VARINT: begin
        if (byte_done) begin
          work_d = ser_rest;
          idx_d  = idx_q + 3'd1;
          if (rec_final) state_d = ST_IDLE;
        end
      end
      ST_FIXED: begin
        if (byte_done) begin
          work_d = work_q >> 8;
          idx_d  = idx_q + 3'd1;
          if (rec_final) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rec_q      <= '0;
      work_q     <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      wt_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_q      <= rec_d;
      work_q     <= work_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      wt_err_q   <= wt_err_d;
    end
  end

`ifdef TREE_ENC_LEN_CHECK_EN
  localparam int DW = $clog2(NUM_MSG_HIERARCHY + 1);

  logic [31:0]   cnt_q [NUM_MSG_HIERARCHY];
  logic [31:0]   cnt_d [NUM_MSG_HIERARCHY];
  logic [DW-1:0] depth_q, depth_d;
  logic          len_err_q, len_err_d;

  // Exhausted counters are popped only at a record boundary, so a record
  // that overruns its enclosing length still flags on the offending byte.
  // Zero-length sub-messages hold nothing to track and are not pushed.
  always_comb begin
    cnt_d     = cnt_q;
    depth_d   = depth_q;
    len_err_d = len_err_q;
    if (byte_done) begin
      for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
        if (DW'(i) < depth_q) begin
          if (cnt_q[i] == 32'd0) len_err_d = 1'b1;
          else                   cnt_d[i]  = cnt_q[i] - 32'd1;
        end
      end
      if (rec_final) begin
        for (int i = NUM_MSG_HIERARCHY - 1; i >= 0; i--) begin
          if (DW'(i) < depth_q && cnt_d[i] == 32'd0) depth_d = DW'(i);
        end
        if (rec_q.wire_type == WT_LEN && rec_q.value != 32'd0) begin
          if (depth_d == DW'(NUM_MSG_HIERARCHY)) begin
            len_err_d = 1'b1;
          end else begin
            for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
              if (DW'(i) == depth_d) cnt_d[i] = rec_q.value;
            end
            depth_d = depth_d + DW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MSG_HIERARCHY; i++) cnt_q[i] <= '0;
      depth_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      depth_q   <= depth_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tree_msg_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_tree_msg_encoder
// Directed and randomized bench for tree_msg_encoder against a byte model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tree_msg_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_field_id = '0;
  logic [2:0]  in_wire_type = '0;
  logic [31:0] in_value = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic        wt_err;
  logic        len_err;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  logic [7:0] exp_q[$];
  logic [2:0] bad_wt [5];

  always #5 clk = ~clk;

  tree_msg_encoder #(.IDENTIFIER_SIZE(5), .NUM_MSG_HIERARCHY(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_field_id  (in_field_id),
    .in_wire_type (in_wire_type),
    .in_value     (in_value),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .wt_err       (wt_err),
    .len_err      (len_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Protobuf varint: base-128 digits, least significant first.
  function automatic void model_varint(input longint v);
    longint x = v;
    longint b;
    do begin
      b = x % 128;
      x = x / 128;
      if (x != 0) b = b + 128;
      exp_q.push_back(8'(b));
    end while (x != 0);
  endfunction

  function automatic void model_record(input int fid, input int wt, input logic [31:0] val);
    longint v = longint'(val);
    exp_q.delete();
    if (wt != 0 && wt != 2 && wt != 5) return;
    model_varint(longint'(fid * 8 + wt));
    if (wt == 5) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(8'(v % 256));
        v = v / 256;
      end
    end else begin
      model_varint(v);
    end
  endfunction

  // mode 0: sink always ready, 1: random backpressure, 2: 3-cycle stall on first byte
  task automatic send(input string name, input int fid, input int wt,
                      input logic [31:0] val, input bit last, input int mode);
    int g;
    int idx;
    int stalls;
    int n;
    bit r;
    n = exp_q.size();
    in_field_id  = 5'(fid);
    in_wire_type = 3'(wt);
    in_value     = val;
    in_last      = last;
    in_valid     = 1'b1;
    g = 0;
    while (in_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    if (n == 0) begin
      check({name, " wt_err pulse"}, 32'(wt_err), 32'd1);
      check({name, " no out_valid"}, 32'(out_valid), 32'd0);
      check({name, " ready again"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      check({name, " wt_err one cycle"}, 32'(wt_err), 32'd0);
      return;
    end
    check({name, " out_valid after accept"}, 32'(out_valid), 32'd1);
    check({name, " in_ready low busy"}, 32'(in_ready), 32'd0);
    idx = 0;
    g = 0;
    stalls = 0;
    while (idx < n && g < 400) begin
      check({name, " out_valid"}, 32'(out_valid), 32'd1);
      check({name, $sformatf(" byte%0d", idx)}, 32'(out_data), 32'(exp_q[idx]));
      check({name, $sformatf(" last%0d", idx)}, 32'(out_last),
            32'(last && (idx == n - 1)));
      if (mode == 2 && idx == 0 && stalls < 3) begin
        r = 1'b0;
        stalls++;
      end else if (mode == 1) begin
        r = ($urandom_range(0, 3) != 0);
      end else begin
        r = 1'b1;
      end
      out_ready = r;
      @(negedge clk);
      g++;
      if (r) idx++;
    end
    out_ready = 1'b0;
    check({name, " all bytes"}, 32'(idx), 32'(n));
    check({name, " idle out_valid"}, 32'(out_valid), 32'd0);
    check({name, " idle in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int fid;
    int wt;
    int pick;
    logic [31:0] val;
    bit last;

    bad_wt[0] = 3'd1; bad_wt[1] = 3'd3; bad_wt[2] = 3'd4;
    bad_wt[3] = 3'd6; bad_wt[4] = 3'd7;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst wt_err", 32'(wt_err), 32'd0);
    check("rst len_err", 32'(len_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("release in_ready", 32'(in_ready), 32'd1);

    exp_q = '{8'h08, 8'h96, 8'h01};
    send("f1_150", 1, 0, 32'd150, 1'b0, 0);
    exp_q = '{8'hA0, 8'h01, 8'h01};
    send("f20_1", 20, 0, 32'd1, 1'b0, 0);
    exp_q = '{8'h25, 8'h78, 8'h56, 8'h34, 8'h12};
    send("f4_fixed", 4, 5, 32'h12345678, 1'b1, 0);
    exp_q = '{8'h12, 8'h03};
    send("f2_len_stall", 2, 2, 32'd3, 1'b0, 2);
    exp_q = '{8'h18, 8'h00};
    send("f3_zero", 3, 0, 32'd0, 1'b1, 1);
    exp_q = '{8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    send("f1_max", 1, 0, 32'hFFFF_FFFF, 1'b0, 1);
    exp_q.delete();
    send("wt3_drop", 7, 3, 32'd99, 1'b1, 0);

    for (int t = 0; t < 30; t++) begin
      fid  = int'($urandom_range(0, 31));
      pick = int'($urandom_range(0, 9));
      if (pick < 3)      wt = 0;
      else if (pick < 6) wt = 2;
      else if (pick < 9) wt = 5;
      else               wt = int'(bad_wt[$urandom_range(0, 4)]);
      val  = $urandom >> $urandom_range(0, 31);
      last = 1'($urandom_range(0, 1));
      model_record(fid, wt, val);
      send($sformatf("rand%0d", t), fid, wt, val, last, 1);
    end

    // Reset while the second byte of a record is on the output.
    in_field_id = 5'd1; in_wire_type = 3'd0; in_value = 32'd150; in_last = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst byte0", 32'(out_data), 32'h08);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("midrst byte1", 32'(out_data), 32'h96);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd0);
    check("midrst out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst in_ready", 32'(in_ready), 32'd1);
    check("postrst out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("postrst no resume", 32'(out_valid), 32'd0);

`ifdef TREE_ENC_LEN_CHECK_EN
    exp_q = '{8'h12, 8'h02};
    send("len_push", 2, 2, 32'd2, 1'b0, 0);
    check("len_err clear", 32'(len_err), 32'd0);
    in_field_id = 5'd1; in_wire_type = 3'd0; in_value = 32'd150; in_last = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("len 1st ok", 32'(len_err), 32'd0);
    @(negedge clk);
    check("len 2nd ok", 32'(len_err), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check("len 3rd err", 32'(len_err), 32'd1);
    repeat (3) @(negedge clk);
    check("len sticky", 32'(len_err), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("len cleared", 32'(len_err), 32'd0);
`else
    check("len_err tied", 32'(len_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
